// File: rtl/multi_edge_detector.sv
// Multi-channel synchronize/debounce/edge detector; EDGE_DEBOUNCE_EN adds the WAIT-state debounce counter.
// Latency: commit at E0+SYNC_STAGES+DB_CYCLES-1 (E0+SYNC_STAGES without debounce); no backpressure, pulses are single-cycle.
module multi_edge_detector #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int DB_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     level,
    input  logic [2*NCH-1:0]   mode,
    input  logic [NCH-1:0]     clear,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     rise,
    output logic [NCH-1:0]     fall,
    output logic [NCH-1:0]     filt_level,
    output logic [NCH-1:0]     event_sticky
);

    typedef enum logic [1:0] {
        STABLE0 = 2'b00,
        WAIT1   = 2'b01,
        STABLE1 = 2'b10,
        WAIT0   = 2'b11
    } state_t;

    if (DB_CYCLES < 1 || DB_CYCLES > (2**CNT_W) - 1 || SYNC_STAGES < 2 || NCH < 1) begin : g_bad_param
        $error("multi_edge_detector: parameter out of range");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic                   filt_q, filt_d;
        logic                   rise_d, fall_d;
        logic                   rise_q, fall_q, tick_q, sticky_q;
`ifdef EDGE_DEBOUNCE_EN
        localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DB_CYCLES);
        logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
        assign cnt_inc = cnt_q + CNT_W'(1);
`endif

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            state_d = state_q;
            filt_d  = filt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
`ifdef EDGE_DEBOUNCE_EN
            cnt_d   = cnt_q;
            case (state_q)
                STABLE0: if (s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = STABLE1;
                        filt_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT1;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT1: if (s) begin
                    if (cnt_inc == DB_LIM) begin
                        state_d = STABLE1;
                        filt_d  = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end
                STABLE1: if (!s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = STABLE0;
                        filt_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT0;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT0: if (!s) begin
                    if (cnt_inc == DB_LIM) begin
                        state_d = STABLE0;
                        filt_d  = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = STABLE1;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = STABLE0;
                    filt_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
`else
            // Without debounce the WAIT encodings are never entered; treat them as corrupt.
            case (state_q)
                STABLE0: if (s) begin
                    state_d = STABLE1;
                    filt_d  = 1'b1;
                    rise_d  = 1'b1;
                end
                STABLE1: if (!s) begin
                    state_d = STABLE0;
                    filt_d  = 1'b0;
                    fall_d  = 1'b1;
                end
                default: begin
                    state_d = STABLE0;
                    filt_d  = 1'b0;
                end
            endcase
`endif
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q   <= '0;
                state_q  <= STABLE0;
                filt_q   <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                tick_q   <= 1'b0;
                sticky_q <= 1'b0;
`ifdef EDGE_DEBOUNCE_EN
                cnt_q    <= '0;
`endif
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], level[i]};
                state_q  <= state_d;
                filt_q   <= filt_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                // Mode is sampled only at the commit edge, so later mode changes never act retroactively.
                tick_q   <= (rise_d & mode[2*i]) | (fall_d & mode[2*i+1]);
                sticky_q <= tick_q | (sticky_q & ~clear[i]);
`ifdef EDGE_DEBOUNCE_EN
                cnt_q    <= cnt_d;
`endif
            end
        end

        assign tick[i]         = tick_q;
        assign rise[i]         = rise_q;
        assign fall[i]         = fall_q;
        assign filt_level[i]   = filt_q;
        assign event_sticky[i] = sticky_q;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised multi-channel successor to the single-channel rising-edge detector.
- Each channel has:
  - an N-stage input synchronizer;
  - a stability filter (debounce);
  - a per-channel edge mode: off, rise, fall or both;
  - registered one-cycle tick outputs and sticky event flags.
- Sits between asynchronous external inputs (buttons, status lines) and synchronous control logic.

Parameters:
NCH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchronizer flop depth per channel (>=2)
CNT_W, 8, debounce counter width
DB_CYCLES, 16, consecutive cycles a new synchronized level must persist before commit (1 <= DB_CYCLES <= 2^CNT_W-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
level  input  NCH  raw asynchronous input levels
mode  input  2*NCH  per-channel mode; bits [2i+1:2i] belong to channel i; 00 off, 01 rise, 10 fall, 11 both
clear  input  NCH  per-channel sticky clear, synchronous, level-sensitive
tick  output  NCH  one-cycle pulse on a committed edge matching the mode
rise  output  NCH  one-cycle pulse on every committed rising edge, not masked by mode
fall  output  NCH  one-cycle pulse on every committed falling edge, not masked by mode
filt_level  output  NCH  debounced, committed level
event_sticky  output  NCH  set by tick, held until cleared

Behaviour:
- Reset (reset=0, asynchronous), per channel:
  - all synchronizer flops 0, FSM in STABLE0, counter 0;
  - filt_level, tick, rise, fall and event_sticky all 0.
  - Reset asserted mid-debounce discards the pending transition.
- Synchronizer:
  - level[i] passes through SYNC_STAGES flops; the last-stage output is s[i].
  - Level stable from edge E0 gives s at edge E0+SYNC_STAGES-1.
- Per-channel FSM states: STABLE0, WAIT1, STABLE1, WAIT0.
  - STABLE0, s=1: go to WAIT1, cnt=1; if DB_CYCLES==1, commit immediately to STABLE1.
  - WAITx, s still differs from filt_level: cnt++; when cnt reaches DB_CYCLES, commit to STABLEx and clear cnt.
  - WAITx, s equals filt_level: return to STABLE(filt_level), clear cnt; no pulse (glitch rejected).
  - STABLE1 / WAIT0 are symmetric for the falling direction.
  - Unreachable state encodings recover to STABLE0.
- Commit effects, all registered at the commit edge and held exactly one cycle:
  - filt_level updates.
  - rise=1 on a 0->1 commit; fall=1 on a 1->0 commit.
  - tick = (rise & mode[0]) | (fall & mode[1]), evaluated with mode sampled at the commit edge.
- Latency: a level stable from edge E0 commits at edge E0+SYNC_STAGES+DB_CYCLES-1.
- Edge spacing:
  - Ticks on the same channel are at least DB_CYCLES cycles apart.
  - Never two consecutive tick cycles, except when DB_CYCLES==1 and the input toggles every cycle.
- Mode changes:
  - Take effect at the next commit only; no retroactive ticks.
  - Mode 00 still tracks filt_level, rise and fall.
- event_sticky:
  - Set on a tick cycle; cleared while clear[i]=1.
  - Simultaneous tick and clear: set wins.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- After reset with level held high, a rising commit occurs as normal, because filt_level resets to 0.

Optional Feature:
- Macro EDGE_DEBOUNCE_EN.
- Defined: WAIT states and the CNT_W counter are implemented as described above.
- Undefined:
  - No counter or WAIT states; the FSM commits on the first edge where s differs from filt_level (equivalent to DB_CYCLES=1).
  - DB_CYCLES and CNT_W are ignored.
  - Latency is E0+SYNC_STAGES.

Test Plan:
- Reset behaviour, default parameters: reset=0 for 3 cycles, level=4'hF -> all outputs 0 during reset. Release reset -> rise=4'hF and tick=4'hF (mode=8'h55) exactly one cycle, 2+16-1=17 cycles after the first sampling edge.
- Glitch rejection: channel 0, level high for 10 cycles then low -> no tick, rise or filt_level change; FSM returns to STABLE0.
- Mode masking: mode=8'b11_10_01_00, all four channels toggle 0->1->0 with 40-cycle holds:
  - ch0: rise and fall pulse, tick never.
  - ch1: tick on rise only.
  - ch2: tick on fall only.
  - ch3: tick on both edges.
- Sticky priority: ch1 tick in the same cycle as clear[1]=1 -> event_sticky[1]=1 next cycle. clear[1]=1 in a later cycle -> 0.
- Reset mid-debounce: assert reset when cnt=8 -> on release, filt_level=0, no pulse from the aborted transition.
- EDGE_DEBOUNCE_EN undefined: level rises at E0 -> tick at E0+2. A 1-cycle glitch produces rise and fall pulses on consecutive cycles.
